// File: rtl/packs.sv
// Shared types and constants for the timer datapath BCD digits.
package packs;

  typedef logic [3:0] BCDnumber_t;

  localparam BCDnumber_t BCD_ZERO = 4'd0;
  localparam BCDnumber_t BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_counter.sv
// Single-digit up/down BCD counter with same-cycle carry/borrow so digits chain
// by wiring overflow of one instance into tick of the next.
module bcd_counter
  import packs::*;
#(
  parameter BCDnumber_t MAX_VAL = BCD_NINE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       sign,
  output BCDnumber_t digit,
  output logic       overflow
);

  if (MAX_VAL == BCD_ZERO || MAX_VAL > BCD_NINE) begin : g_bad_max_val
    $error("bcd_counter: MAX_VAL must be in 1..9");
  end

  BCDnumber_t digit_q;
  BCDnumber_t digit_d;
  logic       at_max;
  logic       at_zero;
  logic       illegal;
  logic       overflow_d;

  assign at_max  = (digit_q == MAX_VAL);
  assign at_zero = (digit_q == BCD_ZERO);
  assign illegal = (digit_q > MAX_VAL);

  always_comb begin
    digit_d = digit_q;
    if (tick) begin
      // An upset value above MAX_VAL recovers to zero rather than counting on.
      if (illegal) begin
        digit_d = BCD_ZERO;
      end else begin
        unique case ({sign, at_max, at_zero})
          3'b000, 3'b001: digit_d = digit_q + 4'd1;
          3'b010:         digit_d = BCD_ZERO;
          3'b100, 3'b110: digit_d = digit_q - 4'd1;
          3'b101:         digit_d = MAX_VAL;
          default:        digit_d = digit_q;
        endcase
      end
    end
  end

  // Combinational so a cascaded digit sees its tick in the same cycle.
  always_comb begin
    overflow_d = 1'b0;
    if (rst && tick && !illegal) begin
      overflow_d = sign ? at_zero : at_max;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit    = digit_q;
  assign overflow = overflow_d;

endmodule

// File: tb/tb_bcd_counter.sv
// Bench for bcd_counter: a two-digit 0..99 cascade and a standalone mod-6 digit,
// checked against whole-number arithmetic models.
module tb_bcd_counter;
  import packs::*;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       sign;
  BCDnumber_t ones_digit;
  BCDnumber_t tens_digit;
  BCDnumber_t five_digit;
  logic       ones_ov;
  logic       tens_ov;
  logic       five_ov;

  bcd_counter #(.MAX_VAL(4'd9)) u_ones (
    .clk(clk), .rst(rst), .tick(tick), .sign(sign),
    .digit(ones_digit), .overflow(ones_ov)
  );

  bcd_counter #(.MAX_VAL(4'd9)) u_tens (
    .clk(clk), .rst(rst), .tick(ones_ov), .sign(sign),
    .digit(tens_digit), .overflow(tens_ov)
  );

  bcd_counter #(.MAX_VAL(4'd5)) u_five (
    .clk(clk), .rst(rst), .tick(tick), .sign(sign),
    .digit(five_digit), .overflow(five_ov)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: cascade as one number 0..99, five-digit as a number 0..5
  int num2;
  int num6;
  int n_vec;
  int n_err;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_digits();
    chk("ones", int'(ones_digit), num2 % 10);
    chk("tens", int'(tens_digit), num2 / 10);
    chk("five", int'(five_digit), num6);
  endtask

  // Drive one cycle: set inputs at negedge, check outputs, advance model at posedge.
  task automatic step(input logic t, input logic s);
    int ones_now;
    @(negedge clk);
    tick = t;
    sign = s;
    #1;
    check_digits();
    ones_now = num2 % 10;
    chk("ones_ov", int'(ones_ov), int'(t && (s ? (ones_now - 1 < 0) : (ones_now + 1 > 9))));
    chk("tens_ov", int'(tens_ov), int'(t && (s ? (num2 == 0) : (num2 == 99))));
    chk("five_ov", int'(five_ov), int'(t && (s ? (num6 == 0) : (num6 == 5))));
    @(posedge clk);
    if (t) begin
      num2 = s ? (num2 + 99) % 100 : (num2 + 1) % 100;
      num6 = s ? (num6 + 5) % 6 : (num6 + 1) % 6;
    end
  endtask

  // Asynchronous reset between edges; must clear digits at once.
  task automatic pulse_reset();
    @(negedge clk);
    tick = 1'b1;
    sign = 1'b1;
    rst  = 1'b0;
    #1;
    num2 = 0;
    num6 = 0;
    check_digits();
    chk("ov_in_rst", int'(ones_ov | tens_ov | five_ov), 0);
    #2;
    tick = 1'b0;
    rst  = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    num2  = 0;
    num6  = 0;
    // Reset held with tick high and sign down: reset must win.
    rst  = 1'b0;
    tick = 1'b1;
    sign = 1'b1;
    #12;
    check_digits();
    chk("ov_in_rst", int'(ones_ov | tens_ov | five_ov), 0);
    #3;
    @(negedge clk);
    rst  = 1'b1;
    tick = 1'b0;

    // Hold with tick low
    for (int i = 0; i < 3; i++) step(1'b0, 1'(i % 2));

    // 12 up ticks: 1..9,0,1,2 on ones; 1..5,0,1.. on five
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Down from 0 after reset: 9,8,7 / 5,4,3
    pulse_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);

    // Count to 6, reset between edges, then resume from 0
    pulse_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    pulse_reset();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Cascade: 10 up ticks from 00 -> 10
    pulse_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("cascade_10", int'({tens_digit, ones_digit}), 8'h10);

    // Cascade: 1 down tick from 00 -> 99
    pulse_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("cascade_99", int'({tens_digit, ones_digit}), 8'h99);

    // Randomized tick/sign, with long up runs to exercise tens carry
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    step(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
